count_display_scanner: RTL

Drives the four-digit multiplexed seven-segment display from the 16-bit event count. Each frame it snapshots the count, converts it to BCD (decimal mode) or passes it through (hex mode), then scans the digits at a parameterised rate. It emits a 4-bit digit value for the downstream hex-to-segment decoder and active-low digit enables. A single clock with an internal tick prescaler replaces a divided display clock; leading zeros are blanked and out-of-range decimal values saturate.

---
 rtl/count_display_scanner.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/count_display_scanner.sv
// Four-digit multiplexed display scanner: snapshots the event count once per frame, converts it
// to BCD (or passes hex through), then drives one digit per prescaler slot with leading-zero blanking.
module count_display_scanner #(
  parameter int SCAN_DIV      = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] count,
  input  logic        hex_mode,
  output logic [3:0]  nibble,
  output logic [3:0]  digit_select,
  output logic        over_range
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          started;
  logic          tick;
  logic          snap;
  logic [3:0]    shift_cnt;
  logic [15:0]   snap_val_p0;
  logic          hex_p0;
  logic [15:0]   bin_p0;
  logic [19:0]   bcd_p0;
  logic [15:0]   disp_p1;
  logic          over_p1;
  logic          vld_p1;
  logic [3:0]    blank;
  logic [3:0]    nib_p2;
  logic [3:0]    sel_p2;

  // Add-3 correction on the four low BCD columns. With a 16-bit input the top column is at most 3
  // before any shift, so it never needs correcting and simply shifts through.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = (b[k*4 +: 4] >= 4'd5) ? b[k*4 +: 4] + 4'd3 : b[k*4 +: 4];
    end
    return r;
  endfunction

  // Returns {over_range, display word}; anything above 9999 pins every digit at 9.
  function automatic logic [16:0] dec_sat(input logic [19:0] b);
    if (b[19:16] != 4'd0) begin
      return {1'b1, 16'h9999};
    end
    return {1'b0, b[15:0]};
  endfunction

  assign tick = (presc == PRESC_LAST);
  assign snap = !started || (tick && (idx == 2'd3));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      idx     <= 2'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (snap) state_nxt = S_SHIFT;
      S_SHIFT: if (shift_cnt == 4'd15) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: snapshot and double-dabble; stage p1: display register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_val_p0 <= 16'd0;
      hex_p0      <= 1'b0;
      bin_p0      <= 16'd0;
      bcd_p0      <= 20'd0;
      shift_cnt   <= 4'd0;
      disp_p1     <= 16'd0;
      over_p1     <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (snap) begin
            snap_val_p0 <= count;
            hex_p0      <= hex_mode;
            bin_p0      <= count;
            bcd_p0      <= 20'd0;
            shift_cnt   <= 4'd0;
          end
        end
        S_SHIFT: begin
          bcd_p0    <= {bcd_p0[18:16], dabble_adj(bcd_p0[15:0]), bin_p0[15]};
          bin_p0    <= {bin_p0[14:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        S_LOAD: begin
          if (hex_p0) begin
            disp_p1 <= snap_val_p0;
            over_p1 <= 1'b0;
          end else begin
            {over_p1, disp_p1} <= dec_sat(bcd_p0);
          end
          vld_p1 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blank = 4'b0000;
    if (BLANK_LEADING) begin
      blank[3] = (disp_p1[15:12] == 4'd0);
      blank[2] = (disp_p1[15:8]  == 8'd0);
      blank[1] = (disp_p1[15:4]  == 12'd0);
    end
  end

  // Stage p2: registered digit drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_p2 <= 4'd0;
      sel_p2 <= 4'b1111;
    end else begin
      nib_p2 <= disp_p1[{idx, 2'b00} +: 4];
      sel_p2 <= (vld_p1 && !blank[idx]) ? ~(4'b0001 << idx) : 4'b1111;
    end
  end

  assign nibble       = nib_p2;
  assign digit_select = sel_p2;
  assign over_range   = over_p1;

  snap_only_in_idle: assert property (@(posedge clk) disable iff (!reset_n) snap |-> state == S_IDLE);

endmodule
